// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus bundle between the bridge (master) and one
// memory-backed slave.
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA : bridge -> slave
//   PREADY, PRDATA, PSLVERR              : slave -> bridge
// Clock and reset are not part of the bundle; they stay plain module ports.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave backed by a small register-array memory.
//   PCLK    : clock, all state changes on the rising edge
//   PRESETn : asynchronous active-low reset (clears FSM, captures and memory)
//   bus     : apb_slave_mem_if.slave (PSEL/PENABLE/PADDR/PWRITE/PWDATA in,
//             PREADY/PRDATA/PSLVERR out)
// Optional feature macro: APB_SLV_WAIT_EN. When defined, WAIT_CYCLES wait
// states are inserted before READY. When undefined, the WAIT state and the
// wait counter are not built and every transfer takes exactly 2 cycles.
//
// state | meaning
// IDLE  | no transfer in progress; setup phase captures address/data/direction
// WAIT  | access phase, counting down wait states (PREADY=0)
// READY | access phase complete (PREADY=1); write commits on PSEL&PENABLE edge
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic            PCLK,
  input logic            PRESETn,
  apb_slave_mem_if.slave bus
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still fits in the compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  capture;
  logic                  do_write;
  logic                  err;
  logic [IDX_W-1:0]      idx;

  assign err = ({1'b0, addr_q} >= DEPTH_LIM);
  assign idx = addr_q[IDX_W-1:0];

`ifdef APB_SLV_WAIT_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 4'd0;
    end else if (capture) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == WAIT) begin
      if (!bus.PSEL)
        wait_cnt <= 4'd0;
      else if (bus.PENABLE && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    do_write  = 1'b0;
    case (state)
      IDLE: begin
        // PENABLE=1 here is a protocol violation and is simply ignored.
        if (bus.PSEL && !bus.PENABLE) begin
          capture = 1'b1;
`ifdef APB_SLV_WAIT_EN
          state_nxt = (WAIT_CYCLES == 0) ? READY : WAIT;
`else
          state_nxt = READY;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      WAIT: begin
        if (!bus.PSEL)
          state_nxt = IDLE;
        else if (bus.PENABLE && (wait_cnt == 4'd1))
          state_nxt = READY;
      end
`endif
      READY: begin
        if (!bus.PSEL) begin
          state_nxt = IDLE;
        end else if (bus.PENABLE) begin
          do_write  = wr_q && !err;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_q  <= bus.PADDR;
        wr_q    <= bus.PWRITE;
        wdata_q <= bus.PWDATA;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else if (do_write) begin
      mem[idx] <= wdata_q;
    end
  end

  // Read data and error are only driven while PREADY is high.
  assign bus.PREADY  = (state == READY);
  assign bus.PSLVERR = (state == READY) && err;
  assign bus.PRDATA  = ((state == READY) && !wr_q && !err) ? mem[idx] : '0;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB slave that sits directly downstream of the APB master bridge.
- Consumes one PSEL line (PSEL1 or PSEL2 per instance) plus PENABLE, PADDR, PWRITE and PWDATA.
- Returns PREADY, PRDATA and PSLVERR.
- Backed by a small register-array memory with optional programmable wait states.
- Addresses outside the memory produce a slave error.

Parameters:
- ADDR_WIDTH, 8, width of PADDR.
- DATA_WIDTH, 8, width of PWDATA and PRDATA.
- MEM_DEPTH, 64, number of memory words; valid addresses are 0 to MEM_DEPTH-1.
- WAIT_CYCLES, 2, wait states inserted per access (only used when APB_SLV_WAIT_EN is defined); range 0 to 15.

Ports:
- PCLK  in  1  clock; everything is on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select from the bridge.
- PENABLE  in  1  access-phase strobe.
- PADDR  in  ADDR_WIDTH  transfer address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data, valid only while PREADY=1.
- PSLVERR  out  1  error response, valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - FSM goes to IDLE; wait counter = 0.
  - Captured address, data and direction = 0; all memory words = 0x00.
  - PREADY=0, PRDATA=0x00, PSLVERR=0, for as long as PRESETn is low.
- FSM states are IDLE, WAIT and READY.
- IDLE:
  - Outputs are 0.
  - On an edge with PSEL=1 and PENABLE=0 (setup phase):
    - Capture PADDR, PWRITE and PWDATA into addr_q, wr_q and wdata_q.
    - Load wait_cnt = WAIT_CYCLES.
    - Go to READY if WAIT_CYCLES=0, else WAIT.
  - PENABLE=1 while in IDLE is a protocol violation: ignored, stay in IDLE, PREADY stays 0.
- WAIT:
  - PREADY=0.
  - Each edge with PSEL=1 and PENABLE=1 decrements wait_cnt.
  - When wait_cnt goes 1 to 0, the next state is READY.
- READY:
  - PREADY=1, combinational from state.
  - err = (addr_q >= MEM_DEPTH); PSLVERR=err.
  - Read with err=0: PRDATA = mem[addr_q]. Otherwise PRDATA=0x00.
- Completion, on an edge in READY with PSEL=1 and PENABLE=1:
  - If wr_q=1 and err=0, write mem[addr_q] <= wdata_q. An erroring write does not modify memory.
  - Next state is IDLE.
- Back-to-back transfers:
  - The bridge returns to setup after completion, so the slave is in IDLE the following cycle and recaptures normally.
  - Minimum transfer is 2 cycles (setup + access) when WAIT_CYCLES=0, and 2+WAIT_CYCLES cycles otherwise.
- Abort: PSEL=0 while in WAIT or READY returns the FSM to IDLE on that edge, with no memory write and wait_cnt cleared.
- Address changes during the access phase are ignored; captured values are used.
- Reset mid-transfer: the transfer is discarded immediately and memory is cleared; no partial write occurs.
- PRDATA and PSLVERR are held at 0 whenever PREADY=0.

Optional Feature:
- Macro: APB_SLV_WAIT_EN.
- Defined: WAIT_CYCLES wait states are inserted as described above.
- Undefined:
  - WAIT_CYCLES is ignored and the WAIT state and wait_cnt are not built.
  - IDLE goes straight to READY, so PREADY=1 in the first access cycle and every transfer takes exactly 2 cycles.

Test Plan:
- Reset check: PRESETn low for 3 cycles while PSEL=1 -> PREADY=0, PRDATA=0x00, PSLVERR=0; reads of addresses 0x00 and 0x3F after reset return 0x00.
- Write then read, macro defined, WAIT_CYCLES=2:
  - Write 0xA5 to 0x10 -> PREADY low for 2 access cycles, high on the 3rd.
  - Read of 0x10 -> PRDATA=0xA5 with PREADY=1 and PSLVERR=0.
- Out-of-range error:
  - Write 0x55 to 0x40 -> PSLVERR=1 together with PREADY=1.
  - Read of 0x40 -> PRDATA=0x00, PSLVERR=1.
  - Word 0x00 is still unchanged.
- Back-to-back transfers: writes 0x11 to 0x01, 0x22 to 0x02 and 0x33 to 0x03 with no idle between -> all three complete; reading them back gives 0x11, 0x22, 0x33.
- Abort: PSEL dropped during WAIT of a write of 0xFF to 0x05 -> FSM back in IDLE, mem[0x05] stays 0x00, next transfer completes normally.
- Macro undefined: write 0x7E to 0x20 -> PREADY=1 in the first access cycle; read back gives 0x7E in a 2-cycle transfer.
